score_display: RTL

SCORE_DISPLAY -- requirements
Module: score_display

---
 rtl/score_display_pkg.sv | 22 ++
 rtl/score_display_bcd_to_seg7.sv | 26 ++
 rtl/score_display.sv | 115 +++++++++++
 3 files changed

// File: rtl/score_display_pkg.sv
// Shared constants for the four-digit multiplexed score display.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package score_display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/score_display_bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes 10-15 are not valid BCD and show a dash.
module bcd_to_seg7
  import score_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// Four-digit multiplexed score display with per-slot blanking, frame snapshots and blink.
// Define SCORE_DISPLAY_LZ_BLANK_EN to suppress a leading zero on the tens digits.
module score_display
  import score_display_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] p1_tens,
  input  logic [3:0] p1_ones,
  input  logic [3:0] p2_tens,
  input  logic [3:0] p2_ones,
  input  logic       blink,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int TW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [TW-1:0] TICK_MAX  = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] TICK_LIT  = TW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0] snap_q;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic       slot_wrap, frame_wrap;
  logic [3:0] cur_digit;
  logic [6:0] dec_seg, digit_seg;

  assign slot_wrap  = (tick_q == TICK_MAX);
  assign frame_wrap = slot_wrap && (idx_q == 2'd3);
  assign cur_digit  = snap_q[idx_q];

  bcd_to_seg7 u_dec (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

  // Tens digits sit at odd slot indices (idx 1 = p2_tens, idx 3 = p1_tens).
`ifdef SCORE_DISPLAY_LZ_BLANK_EN
  assign digit_seg = (idx_q[0] && (cur_digit == 4'd0)) ? SEG_BLANK : dec_seg;
`else
  assign digit_seg = dec_seg;
`endif

  always_comb begin
    tick_d  = slot_wrap ? '0 : tick_q + TW'(1);
    idx_d   = slot_wrap ? idx_q + 2'd1 : idx_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (!blink) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (frame_wrap) begin
      if (bcnt_q == BLINK_MAX) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  // The blink request is used directly so dropping it relights on the next edge.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (!(tick_q < TICK_LIT) && !(blink && phase_q)) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = digit_seg;
      dp_d  = (idx_q != 2'd2);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q  <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      if (frame_wrap) snap_q <= {p1_tens, p1_ones, p2_tens, p2_ones};
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_wrap;

endmodule
